// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and request/ready imem port.
// Define FETCH_PERF_CNT_EN to build the stall/flush performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_Stall,
  input  logic        ID_Stall,
  input  logic        ID_Redirect,
  input  logic [31:0] ID_Target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_Instr,
  output logic [31:0] ID_PC4,
  output logic        ID_Valid,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_target;
  logic        complete;
  logic        stalled;
  logic        redirect;
  logic [31:0] pc4;

  assign imem_addr = pc;
  assign complete  = imem_req & imem_ready;
  assign stalled   = IF_Stall | ID_Stall;
  assign redirect  = ID_Redirect & ~stalled;
  assign pc4       = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      pend_target <= '0;
      imem_req    <= 1'b0;
      ID_Instr    <= NOP_INSTR;
      ID_PC4      <= '0;
      ID_Valid    <= 1'b0;
    end else begin
      imem_req <= 1'b1;
      // Bubble by default; only an unstalled RUN completion loads a real word.
      if (!ID_Stall) begin
        ID_Instr <= NOP_INSTR;
        ID_PC4   <= '0;
        ID_Valid <= 1'b0;
      end
      case (state)
        RUN: begin
          if (redirect) begin
            if (complete) begin
              pc <= ID_Target;
            end else begin
              state       <= PEND;
              pend_target <= ID_Target;
            end
          end else if (complete && !stalled) begin
            pc       <= pc4;
            ID_Instr <= imem_rdata;
            ID_PC4   <= pc4;
            ID_Valid <= 1'b1;
          end
        end
        PEND: begin
          if (redirect) pend_target <= ID_Target;
          // The in-flight word is wrong-path; the newest redirect target wins.
          if (complete) begin
            pc    <= redirect ? ID_Target : pend_target;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic flush_ev;
  assign flush_ev = complete & ((state == PEND) | redirect);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (imem_req && (stalled || !imem_ready)) stall_cnt <= stall_cnt + 32'd1;
      if (flush_ev) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic vs a reference model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst, IF_Stall, ID_Stall, ID_Redirect, imem_ready;
  logic [31:0] ID_Target, imem_rdata;
  logic        imem_req, ID_Valid;
  logic [31:0] imem_addr, ID_Instr, ID_PC4, stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .IF_Stall(IF_Stall), .ID_Stall(ID_Stall),
    .ID_Redirect(ID_Redirect), .ID_Target(ID_Target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .ID_Instr(ID_Instr), .ID_PC4(ID_PC4),
    .ID_Valid(ID_Valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address.
  always_comb imem_rdata = {imem_addr[15:0], ~imem_addr[31:16]} ^ 32'h5A5A_0F0F;

  // Reference model: the fetch address, whether the in-flight fetch is already
  // known to be wrong-path (and where to go next), and what ID holds.
  logic        m_req, m_wrong, m_valid;
  logic [31:0] m_pc, m_next, m_instr, m_pc4, m_sc, m_fc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    logic        got, hold, take;
    logic        n_req, n_wrong, n_valid;
    logic [31:0] n_pc, n_next, n_instr, n_pc4, n_sc, n_fc;
    if (rst) begin
      n_req = 0; n_pc = RST_PC; n_wrong = 0; n_next = 0;
      n_instr = NOP; n_pc4 = 0; n_valid = 0; n_sc = 0; n_fc = 0;
    end else begin
      got  = m_req && imem_ready;
      hold = IF_Stall || ID_Stall;
      take = ID_Redirect && !hold;
      n_req = 1; n_pc = m_pc; n_wrong = m_wrong; n_next = m_next;
      n_sc = m_sc + ((m_req && (hold || !imem_ready)) ? 32'd1 : 32'd0);
      n_fc = m_fc;
      if (ID_Stall) begin
        n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
      end else begin
        n_instr = NOP; n_pc4 = 0; n_valid = 0;
      end
      if (take) n_next = ID_Target;
      if (m_wrong || take) begin
        if (got) begin
          n_pc = n_next; n_wrong = 0; n_fc = m_fc + 1;
        end else begin
          n_wrong = 1;
        end
      end else if (got && !hold) begin
        n_pc = m_pc + 4;
        n_instr = mem_word(m_pc); n_pc4 = m_pc + 4; n_valid = 1;
      end
    end
    @(posedge clk);
    #1;
    m_req = n_req; m_pc = n_pc; m_wrong = n_wrong; m_next = n_next;
    m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid; m_sc = n_sc; m_fc = n_fc;
  endtask

  function automatic logic [161:0] exp_vec();
    logic [31:0] sc, fc;
`ifdef FETCH_PERF_CNT_EN
    sc = m_sc; fc = m_fc;
`else
    sc = 0; fc = 0;
`endif
    return {m_req, m_pc, m_valid, m_instr, (m_valid ? m_pc4 : 32'h0), sc, fc};
  endfunction

  function automatic logic [161:0] dut_vec();
    return {imem_req, imem_addr, ID_Valid, ID_Instr, (m_valid ? ID_PC4 : 32'h0), stall_cnt, flush_cnt};
  endfunction

  task automatic idle_inputs();
    IF_Stall = 0; ID_Stall = 0; ID_Redirect = 0; ID_Target = 0; imem_ready = 1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    tick(); tick();
    n_checks++;
    if ({imem_req, imem_addr, ID_Valid, ID_Instr, ID_PC4, stall_cnt, flush_cnt} !==
        {1'b0, RST_PC, 1'b0, NOP, 32'h0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b addr=%h v=%b instr=%h pc4=%h sc=%0d fc=%0d expected req=0 addr=%h v=0 instr=%h pc4=0 counters 0",
               imem_req, imem_addr, ID_Valid, ID_Instr, ID_PC4, stall_cnt, flush_cnt, RST_PC, NOP);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] want_addr [3] = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008};
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (imem_addr !== want_addr[i] || imem_req !== 1'b1 || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d]: got addr=%h state=%h expected addr=%h state=%h",
                 i, imem_addr, dut_vec(), want_addr[i], exp_vec());
      end
    end
    n_checks++;
    if (ID_Valid !== 1'b1 || ID_PC4 !== 32'h0040_0008) begin
      n_fail++;
      $display("FAIL seq_id_pc4: got v=%b pc4=%h expected v=1 pc4=00400008", ID_Valid, ID_PC4);
    end
  endtask

  task automatic test_stall();
    logic [31:0] addr0, instr0, sc0;
    addr0 = imem_addr; instr0 = ID_Instr; sc0 = stall_cnt;
    IF_Stall = 1; ID_Stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (imem_addr !== addr0 || ID_Instr !== instr0 || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got addr=%h instr=%h expected addr=%h instr=%h", i, imem_addr, ID_Instr, addr0, instr0);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (stall_cnt - sc0 !== 32'd3) begin
      n_fail++;
      $display("FAIL stall_cnt: got delta %0d expected 3", stall_cnt - sc0);
    end
`endif
    IF_Stall = 0; ID_Stall = 0;
    tick();
    n_checks++;
    if (ID_Valid !== 1'b1 || ID_PC4 !== addr0 + 32'd4 || imem_addr !== addr0 + 32'd4) begin
      n_fail++;
      $display("FAIL stall_resume: got v=%b pc4=%h addr=%h expected v=1 pc4=%h addr=%h",
               ID_Valid, ID_PC4, imem_addr, addr0 + 32'd4, addr0 + 32'd4);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] fc0;
    fc0 = flush_cnt;
    ID_Redirect = 1; ID_Target = 32'h0040_0100;
    tick();
    ID_Redirect = 0;
    n_checks++;
    if (imem_addr !== 32'h0040_0100 || ID_Valid !== 1'b0 || ID_Instr !== NOP || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL redirect_ready: got addr=%h v=%b instr=%h expected addr=00400100 v=0 instr=%h", imem_addr, ID_Valid, ID_Instr, NOP);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (flush_cnt - fc0 !== 32'd1) begin
      n_fail++;
      $display("FAIL redirect_flush_cnt: got delta %0d expected 1", flush_cnt - fc0);
    end
`endif
  endtask

  task automatic test_pend();
    logic [31:0] addr0, fc0;
    tick();
    addr0 = imem_addr; fc0 = flush_cnt;
    ID_Redirect = 1; ID_Target = 32'h0040_0200; imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      ID_Redirect = 0;
      n_checks++;
      if (imem_addr !== addr0 || ID_Valid !== 1'b0 || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL pend_hold[%0d]: got addr=%h v=%b expected addr=%h v=0", i, imem_addr, ID_Valid, addr0);
      end
    end
    imem_ready = 1;
    tick();
    n_checks++;
    if (imem_addr !== 32'h0040_0200 || ID_Valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL pend_complete: got addr=%h v=%b expected addr=00400200 v=0", imem_addr, ID_Valid);
    end
`ifdef FETCH_PERF_CNT_EN
    n_checks++;
    if (flush_cnt - fc0 !== 32'd1) begin
      n_fail++;
      $display("FAIL pend_flush_cnt: got delta %0d expected 1", flush_cnt - fc0);
    end
`endif
    tick();
    n_checks++;
    if (ID_Valid !== 1'b1 || ID_Instr !== mem_word(32'h0040_0200) || ID_PC4 !== 32'h0040_0204) begin
      n_fail++;
      $display("FAIL pend_target_fetch: got v=%b instr=%h pc4=%h expected v=1 instr=%h pc4=00400204",
               ID_Valid, ID_Instr, ID_PC4, mem_word(32'h0040_0200));
    end
  endtask

  task automatic test_redirect_stall();
    logic [31:0] addr0, instr0, pc40;
    logic        v0;
    addr0 = imem_addr; instr0 = ID_Instr; pc40 = ID_PC4; v0 = ID_Valid;
    ID_Redirect = 1; ID_Target = 32'h0000_1000; ID_Stall = 1;
    tick(); tick();
    ID_Redirect = 0; ID_Stall = 0;
    n_checks++;
    if ({imem_addr, ID_Instr, ID_PC4, ID_Valid} !== {addr0, instr0, pc40, v0} || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL redirect_stalled: got addr=%h instr=%h pc4=%h v=%b expected addr=%h instr=%h pc4=%h v=%b",
               imem_addr, ID_Instr, ID_PC4, ID_Valid, addr0, instr0, pc40, v0);
    end
  endtask

  task automatic test_wrap();
    ID_Redirect = 1; ID_Target = 32'hFFFF_FFFC;
    tick();
    ID_Redirect = 0;
    tick();
    n_checks++;
    if (imem_addr !== 32'h0 || ID_PC4 !== 32'h0 || ID_Valid !== 1'b1 || ID_Instr !== mem_word(32'hFFFF_FFFC)) begin
      n_fail++;
      $display("FAIL pc_wrap: got addr=%h pc4=%h v=%b expected addr=0 pc4=0 v=1", imem_addr, ID_PC4, ID_Valid);
    end
  endtask

  task automatic test_reset_midfetch();
    imem_ready = 0;
    tick();
    rst = 1;
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RST_PC || ID_Valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_midfetch: got req=%b addr=%h v=%b expected req=0 addr=%h v=0", imem_req, imem_addr, ID_Valid, RST_PC);
    end
    rst = 0; imem_ready = 1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC || ID_Valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_ready: got req=%b addr=%h v=%b expected req=1 addr=%h v=0", imem_req, imem_addr, ID_Valid, RST_PC);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 79) == 0);
      IF_Stall    = ($urandom_range(0, 5) == 0);
      ID_Stall    = ($urandom_range(0, 6) == 0);
      imem_ready  = ($urandom_range(0, 3) != 0);
      ID_Redirect = ($urandom_range(0, 7) == 0);
      ID_Target   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
      end
    end
    idle_inputs(); rst = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_pend();
    test_redirect_stall();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
